// File: rtl/operand_stage_pkg.sv
// Shared widths, opcode encoding and register index type for the operand stage.
// DATA_WIDTH, ALU_OP_AMT and REG_AMT may be overridden on the command line.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ALU_OP_AMT
`define ALU_OP_AMT 8
`endif
`ifndef REG_AMT
`define REG_AMT 8
`endif

package operand_stage_pkg;

  localparam int DATA_W      = `DATA_WIDTH;
  localparam int OP_W        = $clog2(`ALU_OP_AMT);
  localparam int DEF_REG_AMT = `REG_AMT;

  typedef logic [DATA_W-1:0]               t_data;
  typedef logic [$clog2(DEF_REG_AMT)-1:0]  t_reg_idx;

  // ADD..SHFL must stay contiguous and last: they are the two-operand ops.
  typedef enum logic [OP_W-1:0] {
    LD,
    OUT,
    ADD,
    SUB,
    NAND,
    NOR,
    XOR,
    SHFL
  } t_opcode;

  function automatic logic op_writes_rd(t_opcode op);
    return op != OUT;
  endfunction

  function automatic logic op_needs_a(t_opcode op);
    return op != LD;
  endfunction

  function automatic logic op_needs_b(t_opcode op);
    return (op != LD) && (op != OUT);
  endfunction

endpackage

// File: rtl/operand_stage_if.sv
// Bundles the decode handshake, the EX pipeline register outputs and the
// writeback bus of the operand stage; slave is the stage side.
interface operand_stage_if
  import operand_stage_pkg::*;
#(
  parameter int REG_AMT = DEF_REG_AMT
) ();

  localparam int RIDX_W = $clog2(REG_AMT);

  logic              in_valid;
  logic              in_ready;
  t_opcode           in_op;
  logic [RIDX_W-1:0] in_rd;
  logic [RIDX_W-1:0] in_rs1;
  logic [RIDX_W-1:0] in_rs2;
  t_data             in_imm;

  logic              ex_valid;
  logic              ex_ready;
  t_opcode           ex_op;
  t_data             ex_a;
  t_data             ex_b;
  logic [RIDX_W-1:0] ex_rd;
  logic              ex_we;
  t_data             ex_result;

  logic              wb_we;
  logic [RIDX_W-1:0] wb_rd;
  t_data             wb_data;

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
    input  ex_ready, ex_result,
    input  wb_we, wb_rd, wb_data,
    output in_ready,
    output ex_valid, ex_op, ex_a, ex_b, ex_rd, ex_we
  );

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
    output ex_ready, ex_result,
    output wb_we, wb_rd, wb_data,
    input  in_ready,
    input  ex_valid, ex_op, ex_a, ex_b, ex_rd, ex_we
  );

endinterface

// File: rtl/operand_stage_reg_file.sv
// General register file: two asynchronous read ports, one synchronous write
// port, asynchronously cleared to zero.
module operand_stage_reg_file
  import operand_stage_pkg::*;
#(
  parameter int REG_AMT = DEF_REG_AMT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [$clog2(REG_AMT)-1:0] waddr,
  input  t_data                      wdata,
  input  logic [$clog2(REG_AMT)-1:0] raddr_a,
  output t_data                      rdata_a,
  input  logic [$clog2(REG_AMT)-1:0] raddr_b,
  output t_data                      rdata_b
);

  t_data mem [REG_AMT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_AMT; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/operand_stage.sv
// Decode-to-execute stage: resolves operands and loads the EX register feeding the ALU.
// OPERAND_FWD_EN selects forwarding from EX/WB; undefined, a scoreboard stalls on hazards.
module operand_stage
  import operand_stage_pkg::*;
#(
  parameter int REG_AMT = DEF_REG_AMT
) (
  input logic          clk,
  input logic          rst,
  operand_stage_if.slave bus
);

  localparam int RIDX_W = $clog2(REG_AMT);

  t_data             rf_a;
  t_data             rf_b;
  t_data             opnd_a;
  t_data             opnd_b;
  logic              advance;
  logic              hazard;
  logic              accept;

  logic              ex_valid_q;
  t_opcode           ex_op_q;
  t_data             ex_a_q;
  t_data             ex_b_q;
  logic [RIDX_W-1:0] ex_rd_q;
  logic              ex_we_q;

  operand_stage_reg_file #(.REG_AMT(REG_AMT)) u_reg_file (
    .clk     (clk),
    .rst     (rst),
    .we      (bus.wb_we),
    .waddr   (bus.wb_rd),
    .wdata   (bus.wb_data),
    .raddr_a (bus.in_rs1),
    .rdata_a (rf_a),
    .raddr_b (bus.in_rs2),
    .rdata_b (rf_b)
  );

`ifdef OPERAND_FWD_EN
  // The instruction in EX is younger than the one in writeback, so it wins.
  always_comb begin
    opnd_a = rf_a;
    if (bus.wb_we && (bus.wb_rd == bus.in_rs1)) opnd_a = bus.wb_data;
    if (ex_valid_q && ex_we_q && (ex_rd_q == bus.in_rs1)) opnd_a = bus.ex_result;
    opnd_b = rf_b;
    if (bus.wb_we && (bus.wb_rd == bus.in_rs2)) opnd_b = bus.wb_data;
    if (ex_valid_q && ex_we_q && (ex_rd_q == bus.in_rs2)) opnd_b = bus.ex_result;
  end

  assign hazard = 1'b0;
`else
  logic [REG_AMT-1:0] pending;
  logic               unused_ex_result;

  assign unused_ex_result = ^bus.ex_result;

  // Set after clear so a same-index accept and writeback leaves the bit pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      if (bus.wb_we) pending[bus.wb_rd] <= 1'b0;
      if (accept && op_writes_rd(bus.in_op)) pending[bus.in_rd] <= 1'b1;
    end
  end

  assign opnd_a = rf_a;
  assign opnd_b = rf_b;
  assign hazard = bus.in_valid &
                  ((op_needs_a(bus.in_op) & pending[bus.in_rs1]) |
                   (op_needs_b(bus.in_op) & pending[bus.in_rs2]));
`endif

  assign advance      = bus.ex_ready | ~ex_valid_q;
  assign bus.in_ready = advance & ~hazard & ~rst;
  assign accept       = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_op_q    <= LD;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_rd_q    <= '0;
      ex_we_q    <= 1'b0;
    end else if (advance) begin
      ex_valid_q <= accept;
      if (accept) begin
        ex_op_q <= bus.in_op;
        ex_a_q  <= (bus.in_op == LD) ? bus.in_imm : opnd_a;
        ex_b_q  <= opnd_b;
        ex_rd_q <= bus.in_rd;
        ex_we_q <= op_writes_rd(bus.in_op);
      end
    end
  end

  assign bus.ex_valid = ex_valid_q;
  assign bus.ex_op    = ex_op_q;
  assign bus.ex_a     = ex_a_q;
  assign bus.ex_b     = ex_b_q;
  assign bus.ex_rd    = ex_rd_q;
  assign bus.ex_we    = ex_we_q;

endmodule

// File: tb/tb_operand_stage.sv
// Self-checking bench for operand_stage: expected EX contents are queued on accept
// and compared when the instruction appears in the EX register.
module tb_operand_stage;
  import operand_stage_pkg::*;

  typedef struct packed {
    t_opcode  op;
    t_data    a;
    t_data    b;
    t_reg_idx rd;
    logic     we;
  } ex_t;

  logic clk = 1'b0;
  logic rst;

  operand_stage_if bus ();

  operand_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  ex_t   exp_q[$];
  t_data mdl_rf [DEF_REG_AMT];
  int    n_tests = 0;
  int    n_fail  = 0;

  function automatic t_data mdl_read(t_reg_idx rs);
`ifdef OPERAND_FWD_EN
    if (bus.wb_we && (bus.wb_rd == rs)) return bus.wb_data;
`endif
    return mdl_rf[rs];
  endfunction

  task automatic tick();
    @(posedge clk);
    if (bus.wb_we && !rst) mdl_rf[bus.wb_rd] = bus.wb_data;
    #1;
  endtask

  task automatic issue(input t_opcode op, input t_reg_idx rd, input t_reg_idx rs1,
                       input t_reg_idx rs2, input t_data imm, output logic acc);
    ex_t e;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_rd    = rd;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_imm   = imm;
    #1;
    acc  = bus.in_ready;
    e.op = op;
    e.a  = (op == LD) ? imm : mdl_read(rs1);
    e.b  = mdl_read(rs2);
    e.rd = rd;
    e.we = (op != OUT);
    if (acc) exp_q.push_back(e);
  endtask

  task automatic test_reset();
    ex_t got, exp;
    #3;
    exp = '0;
    exp.op = LD;
    got = {bus.ex_op, bus.ex_a, bus.ex_b, bus.ex_rd, bus.ex_we};
    n_tests++;
    if (bus.ex_valid !== 1'b0 || got !== exp) begin
      n_fail++;
      $display("FAIL reset_ex valid=%b got=%h exp=%h", bus.ex_valid, got, exp);
    end
    n_tests++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_in_ready got=%b exp=1", bus.in_ready);
    end
  endtask

  task automatic test_ld();
    ex_t got, exp;
    logic acc;
    issue(LD, 3'd2, 3'd0, 3'd0, 8'h5A, acc);
    tick();
    bus.in_valid = 1'b0;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : ex_t'(0);
    got = {bus.ex_op, bus.ex_a, bus.ex_b, bus.ex_rd, bus.ex_we};
    n_tests++;
    if (!acc || bus.ex_valid !== 1'b1 || got !== exp) begin
      n_fail++;
      $display("FAIL ld acc=%b valid=%b got=%h exp=%h", acc, bus.ex_valid, got, exp);
    end
    tick();
    n_tests++;
    if (bus.ex_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_idle ex_valid got=%b exp=0", bus.ex_valid);
    end
  endtask

  task automatic test_wb_read();
    ex_t got, exp;
    logic acc;
    bus.wb_we = 1'b1; bus.wb_rd = 3'd3; bus.wb_data = 8'h11;
    tick();
    bus.wb_we = 1'b0;
    issue(ADD, 3'd4, 3'd3, 3'd3, 8'h00, acc);
    tick();
    bus.in_valid = 1'b0;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : ex_t'(0);
    got = {bus.ex_op, bus.ex_a, bus.ex_b, bus.ex_rd, bus.ex_we};
    n_tests++;
    if (!acc || bus.ex_valid !== 1'b1 || got !== exp) begin
      n_fail++;
      $display("FAIL wb_then_read acc=%b got=%h exp=%h", acc, got, exp);
    end
    // Same-cycle writeback and read of r3: old value without bypass, new with it.
    bus.wb_we = 1'b1; bus.wb_rd = 3'd3; bus.wb_data = 8'h22;
    issue(ADD, 3'd6, 3'd3, 3'd3, 8'h00, acc);
    tick();
    bus.wb_we = 1'b0;
    bus.in_valid = 1'b0;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : ex_t'(0);
    got = {bus.ex_op, bus.ex_a, bus.ex_b, bus.ex_rd, bus.ex_we};
    n_tests++;
    if (!acc || bus.ex_valid !== 1'b1 || got !== exp) begin
      n_fail++;
      $display("FAIL wb_same_cycle acc=%b got=%h exp=%h", acc, got, exp);
    end
  endtask

`ifdef OPERAND_FWD_EN
  task automatic test_forward();
    ex_t got, exp;
    logic acc;
    for (int k = 0; k < 2; k++) begin
      issue(ADD, 3'd1, 3'd3, 3'd3, 8'h00, acc);
      tick();
      bus.in_valid = 1'b0;
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : ex_t'(0);
      got = {bus.ex_op, bus.ex_a, bus.ex_b, bus.ex_rd, bus.ex_we};
      n_tests++;
      if (!acc || got !== exp) begin
        n_fail++;
        $display("FAIL fwd_producer%0d acc=%b got=%h exp=%h", k, acc, got, exp);
      end
      bus.ex_result = 8'h24;
      if (k == 1) begin
        bus.wb_we = 1'b1; bus.wb_rd = 3'd1; bus.wb_data = 8'h99;
      end
      issue(SUB, 3'd2, 3'd1, 3'd3, 8'h00, acc);
      if (acc) exp_q[$].a = 8'h24;
      tick();
      bus.wb_we = 1'b0;
      bus.ex_result = 8'h00;
      bus.in_valid = 1'b0;
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : ex_t'(0);
      got = {bus.ex_op, bus.ex_a, bus.ex_b, bus.ex_rd, bus.ex_we};
      n_tests++;
      if (!acc || bus.ex_valid !== 1'b1 || got !== exp) begin
        n_fail++;
        $display("FAIL fwd_ex_result%0d acc=%b got=%h exp=%h", k, acc, got, exp);
      end
    end
  endtask
`else
  task automatic test_stall();
    ex_t got, exp;
    logic acc;
    issue(ADD, 3'd1, 3'd3, 3'd3, 8'h00, acc);
    tick();
    bus.in_valid = 1'b0;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : ex_t'(0);
    got = {bus.ex_op, bus.ex_a, bus.ex_b, bus.ex_rd, bus.ex_we};
    n_tests++;
    if (!acc || got !== exp) begin
      n_fail++;
      $display("FAIL stall_producer acc=%b got=%h exp=%h", acc, got, exp);
    end
    issue(XOR, 3'd5, 3'd3, 3'd1, 8'h00, acc);
    n_tests++;
    if (acc !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_first in_ready got=%b exp=0", acc);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold%0d in_ready got=%b exp=0", i, bus.in_ready);
      end
    end
    bus.wb_we = 1'b1; bus.wb_rd = 3'd1; bus.wb_data = 8'h33;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_wb_cycle in_ready got=%b exp=0", bus.in_ready);
    end
    tick();
    bus.wb_we = 1'b0;
    issue(XOR, 3'd5, 3'd3, 3'd1, 8'h00, acc);
    n_tests++;
    if (acc !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release in_ready got=%b exp=1", acc);
    end
    tick();
    bus.in_valid = 1'b0;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : ex_t'(0);
    got = {bus.ex_op, bus.ex_a, bus.ex_b, bus.ex_rd, bus.ex_we};
    n_tests++;
    if (bus.ex_valid !== 1'b1 || got !== exp) begin
      n_fail++;
      $display("FAIL stall_consumer got=%h exp=%h", got, exp);
    end
    issue(OUT, 3'd0, 3'd3, 3'd3, 8'h00, acc);
    tick();
    bus.in_valid = 1'b0;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : ex_t'(0);
    got = {bus.ex_op, bus.ex_a, bus.ex_b, bus.ex_rd, bus.ex_we};
    n_tests++;
    if (!acc || got !== exp) begin
      n_fail++;
      $display("FAIL out_producer acc=%b got=%h exp=%h", acc, got, exp);
    end
    issue(XOR, 3'd5, 3'd3, 3'd0, 8'h00, acc);
    n_tests++;
    if (acc !== 1'b1) begin
      n_fail++;
      $display("FAIL out_no_stall in_ready got=%b exp=1", acc);
    end
    tick();
    bus.in_valid = 1'b0;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : ex_t'(0);
    got = {bus.ex_op, bus.ex_a, bus.ex_b, bus.ex_rd, bus.ex_we};
    n_tests++;
    if (bus.ex_valid !== 1'b1 || got !== exp) begin
      n_fail++;
      $display("FAIL out_consumer got=%h exp=%h", got, exp);
    end
  endtask
`endif

  task automatic test_backpressure();
    ex_t got, exp, frozen;
    logic acc;
    issue(SUB, 3'd7, 3'd3, 3'd3, 8'h00, acc);
    tick();
    bus.ex_ready = 1'b0;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : ex_t'(0);
    issue(LD, 3'd0, 3'd0, 3'd0, 8'h77, acc);
    n_tests++;
    if (acc !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_in_ready got=%b exp=0", acc);
    end
    frozen = exp;
    for (int i = 0; i < 3; i++) begin
      got = {bus.ex_op, bus.ex_a, bus.ex_b, bus.ex_rd, bus.ex_we};
      n_tests++;
      if (bus.ex_valid !== 1'b1 || bus.in_ready !== 1'b0 || got !== frozen) begin
        n_fail++;
        $display("FAIL bp_hold%0d valid=%b rdy=%b got=%h exp=%h", i, bus.ex_valid,
                 bus.in_ready, got, frozen);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    bus.ex_ready = 1'b1;
    tick();
    n_tests++;
    if (bus.ex_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release ex_valid got=%b exp=0", bus.ex_valid);
    end
  endtask

  task automatic test_reset_mid();
    ex_t got, exp;
    logic acc;
    issue(ADD, 3'd4, 3'd3, 3'd1, 8'h00, acc);
    tick();
    bus.in_valid = 1'b0;
    bus.ex_ready = 1'b0;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : ex_t'(0);
    got = {bus.ex_op, bus.ex_a, bus.ex_b, bus.ex_rd, bus.ex_we};
    n_tests++;
    if (!acc || bus.ex_valid !== 1'b1 || got !== exp) begin
      n_fail++;
      $display("FAIL pre_reset_ex acc=%b got=%h exp=%h", acc, got, exp);
    end
    #2 rst = 1'b1;
    #1;
    exp = '0;
    exp.op = LD;
    got = {bus.ex_op, bus.ex_a, bus.ex_b, bus.ex_rd, bus.ex_we};
    n_tests++;
    if (bus.ex_valid !== 1'b0 || bus.in_ready !== 1'b0 || got !== exp) begin
      n_fail++;
      $display("FAIL mid_reset valid=%b rdy=%b got=%h exp=%h", bus.ex_valid,
               bus.in_ready, got, exp);
    end
    exp_q.delete();
    for (int i = 0; i < DEF_REG_AMT; i++) mdl_rf[i] = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    bus.ex_ready = 1'b1;
    issue(ADD, 3'd5, 3'd7, 3'd4, 8'h00, acc);
    n_tests++;
    if (acc !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_clears_pending in_ready got=%b exp=1", acc);
    end
    tick();
    bus.in_valid = 1'b0;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : ex_t'(0);
    got = {bus.ex_op, bus.ex_a, bus.ex_b, bus.ex_rd, bus.ex_we};
    n_tests++;
    if (bus.ex_valid !== 1'b1 || got !== exp) begin
      n_fail++;
      $display("FAIL reset_clears_regs got=%h exp=%h", got, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = LD;
    bus.in_rd     = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_imm    = '0;
    bus.ex_ready  = 1'b1;
    bus.ex_result = '0;
    bus.wb_we     = 1'b0;
    bus.wb_rd     = '0;
    bus.wb_data   = '0;
    for (int i = 0; i < DEF_REG_AMT; i++) mdl_rf[i] = '0;

    test_reset();
    test_ld();
    test_wb_read();
`ifdef OPERAND_FWD_EN
    test_forward();
`else
    test_stall();
`endif
    test_backpressure();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout sim_time=%0t limit=100000", $time);
    $fatal(1, "timeout");
  end

endmodule
